text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Write-side companion of the text-mode tile layer: accepts a character stream over a valid/ready handshake and writes it into the 16x32 text buffer.
- Writes go through the buffer's write port at address {row[3:0], col[4:0]}.
- Maintains a cursor; interprets LF, CR, BS and FF control codes.
- On line advance, clears the destination line; on FF, clears the whole screen.
- Sits between a character source (UART RX, CPU port) and the text buffer RAM, all in the pixel-clock domain.

Parameters:
- COL_BITS, 5, log2 of columns per row (32).
- ROW_BITS, 4, log2 of rows (16).
- CLEAR_CHAR, 8'h00, tile code written by clear operations and backspace.

Ports:
- i_pix_clk  in  1  pixel clock; all logic is on its rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_char_valid  in  1  source presents i_char.
- i_char  in  8  character or control code.
- o_char_ready  out  1  block can accept a character this cycle.
- o_wr_en  out  1  text buffer write strobe.
- o_wr_addr  out  ROW_BITS+COL_BITS  write address, {row, col}.
- o_wr_data  out  8  write data.
- o_cursor_col  out  COL_BITS  current cursor column.
- o_cursor_row  out  ROW_BITS  current cursor row.
- o_busy  out  1  a clear operation is in progress.

Behaviour:
- Reset (i_reset high at a clock edge):
  - state=IDLE, cursor=(0,0).
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0.
  - o_char_ready is low for every cycle in which i_reset is high.
- States:
  - IDLE.
  - CLR_LINE: 2^COL_BITS cycles.
  - CLR_SCREEN: 2^(ROW_BITS+COL_BITS) cycles.
- o_char_ready = (state==IDLE) && !i_reset, combinational. o_busy is registered and equals (state!=IDLE).
- Accept occurs when i_char_valid && o_char_ready. A character is consumed exactly once. i_char is sampled only on accept.
- Write outputs are registered: o_wr_en/addr/data are valid the cycle after accept. o_wr_en is low on all non-write cycles.
- Accept of 0x0A (LF):
  - col<=0; row<=row+1 (wraps 15->0); no write.
  - Enter CLR_LINE targeting the new row.
- Accept of 0x0D (CR): col<=0; no write; remain IDLE.
- Accept of 0x08 (BS):
  - If col>0: col<=col-1, and write CLEAR_CHAR at {row, col-1}.
  - If col==0: no cursor change, no write.
- Accept of 0x0C (FF): cursor<=(0,0); enter CLR_SCREEN.
- Accept of any other code:
  - Write i_char at {row, col}.
  - If col<31: col<=col+1.
  - If col==31: col<=0, row<=row+1 (wrap), and enter CLR_LINE for the new row.
- CLR_LINE:
  - Clear counter runs 0..31. Each cycle writes CLEAR_CHAR at {target_row, cnt}.
  - After the write of cnt=31, return to IDLE; o_char_ready rises the following cycle.
  - The first clear write is issued the cycle after the write for the character that caused the wrap (if any); the two writes never collide.
- CLR_SCREEN: counter runs 0..511, writing CLEAR_CHAR at address cnt; then IDLE. The cursor stays (0,0).
- Timing: total busy time is 32 cycles for a line clear and 512 cycles for a screen clear, both measured from the first clear write.
- The cursor outputs update on the edge that accepts the character.
- Reset mid-clear: aborts immediately, with no further writes, cursor (0,0), IDLE (unless the macro below is set).
- i_char_valid while busy: held off (ready low); the source must keep i_char stable.
- Counter widths are exact; wrap-around is natural modulo arithmetic with no extra compare.

Optional Feature:
- Macro TEXT_WRITER_CLEAR_ON_RESET_EN.
- Defined:
  - Reset places the block in CLR_SCREEN with counter 0, o_busy=1 the cycle after reset deasserts.
  - 512 CLEAR_CHAR writes follow, then IDLE.
  - o_char_ready is low throughout.
- Undefined: reset enters IDLE; buffer contents are untouched (the initial memory image is preserved).

Test Plan:
- Reset, then send 'A'(0x41), 'B'(0x42) back-to-back → writes addr 0x000=0x41, 0x001=0x42 on consecutive cycles; cursor ends (row0, col2); ready stays high.
- Cursor at col 31, row 3, send 0x58 → write 0x07F=0x58; cursor (4,0); o_busy=1 for 32 cycles; writes 0x080..0x09F=CLEAR_CHAR; ready low until done.
- Cursor (15,5), send 0x0A → no char write; cursor (0,0); clears 0x000..0x01F; next char lands at 0x000.
- Cursor (2,0), send 0x08 → no write, cursor unchanged. Cursor (2,4), send 0x08 → write 0x043=CLEAR_CHAR; cursor (2,3).
- Send 0x0C, assert i_reset at clear count 100 → no writes after reset edge; cursor (0,0); ready high the cycle after reset drops (macro off).
- With TEXT_WRITER_CLEAR_ON_RESET_EN: release reset, hold i_char_valid=1 with 0x41 → exactly 512 clear writes 0x000..0x1FF, then 0x41 written at 0x000 once.

Source files
------------

// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
//
// Write-side companion of the text-mode tile layer. Accepts a character stream
// over a valid/ready handshake and writes it into the text buffer through the
// buffer's write port at address {row, col}. A cursor is maintained and the
// control codes LF (0x0A), CR (0x0D), BS (0x08) and FF (0x0C) are interpreted.
// Advancing to a new line clears that line; FF clears the whole screen.
//
// Ports:
//   i_pix_clk     in   pixel clock, all logic on its rising edge
//   i_reset       in   synchronous reset, active-high
//   i_char_valid  in   source presents i_char
//   i_char        in   character or control code (sampled only on accept)
//   o_char_ready  out  block can accept a character this cycle (combinational)
//   o_wr_en       out  text buffer write strobe (registered)
//   o_wr_addr     out  write address {row, col} (registered)
//   o_wr_data     out  write data (registered)
//   o_cursor_col  out  current cursor column
//   o_cursor_row  out  current cursor row
//   o_busy        out  a clear operation is in progress (registered)
//
// Optional build macro:
//   TEXT_WRITER_CLEAR_ON_RESET_EN - when defined, reset starts a full-screen
//   clear (512 writes of CLEAR_CHAR once reset is released). When undefined,
//   reset goes straight to IDLE and leaves the buffer contents untouched.
// -----------------------------------------------------------------------------
module text_writer #(
  parameter int         COL_BITS   = 5,
  parameter int         ROW_BITS   = 4,
  parameter logic [7:0] CLEAR_CHAR = 8'h00
) (
  input  logic                         i_pix_clk,
  input  logic                         i_reset,
  input  logic                         i_char_valid,
  input  logic [7:0]                   i_char,
  output logic                         o_char_ready,
  output logic                         o_wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] o_wr_addr,
  output logic [7:0]                   o_wr_data,
  output logic [COL_BITS-1:0]          o_cursor_col,
  output logic [ROW_BITS-1:0]          o_cursor_row,
  output logic                         o_busy
);

  localparam int AW = ROW_BITS + COL_BITS;

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  localparam logic [COL_BITS-1:0] COL_ZERO = '0;
  localparam logic [COL_BITS-1:0] COL_ONE  = 1;
  localparam logic [COL_BITS-1:0] COL_MAX  = '1;
  localparam logic [ROW_BITS-1:0] ROW_ZERO = '0;
  localparam logic [ROW_BITS-1:0] ROW_ONE  = 1;
  localparam logic [AW-1:0]       CNT_ZERO = '0;
  localparam logic [AW-1:0]       CNT_ONE  = 1;
  localparam logic [AW-1:0]       CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                accept;

  // Ready is gated by reset so a character presented during reset is never
  // consumed.
  assign o_char_ready = (state_q == IDLE) && !i_reset;
  assign accept       = i_char_valid && o_char_ready;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;   // address/data hold between writes
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (i_char)
            CODE_LF: begin
              // The row register already points at the new line, so the clear
              // walks {row_q, cnt} without a separate target-row register.
              col_d   = COL_ZERO;
              row_d   = row_q + ROW_ONE;
              cnt_d   = CNT_ZERO;
              state_d = CLR_LINE;
            end
            CODE_CR: begin
              col_d = COL_ZERO;
            end
            CODE_BS: begin
              if (col_q != COL_ZERO) begin
                col_d     = col_q - COL_ONE;
                wr_en_d   = 1'b1;
                wr_addr_d = {row_q, col_q - COL_ONE};
                wr_data_d = CLEAR_CHAR;
              end
            end
            CODE_FF: begin
              col_d   = COL_ZERO;
              row_d   = ROW_ZERO;
              cnt_d   = CNT_ZERO;
              state_d = CLR_SCREEN;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = {row_q, col_q};
              wr_data_d = i_char;
              // Column wraps naturally to 0 on the last column.
              col_d     = col_q + COL_ONE;
              if (col_q == COL_MAX) begin
                row_d   = row_q + ROW_ONE;
                cnt_d   = CNT_ZERO;
                state_d = CLR_LINE;
              end
            end
          endcase
        end
      end

      CLR_LINE: begin
        // The character write (if any) was registered on the accepting edge,
        // so the first clear write always lands one cycle later.
        wr_en_d   = 1'b1;
        wr_addr_d = {row_q, cnt_q[COL_BITS-1:0]};
        wr_data_d = CLEAR_CHAR;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q[COL_BITS-1:0] == COL_MAX) begin
          state_d = IDLE;
        end
      end

      CLR_SCREEN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CLEAR_CHAR;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_pix_clk) begin
    if (i_reset) begin
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
      state_q <= CLR_SCREEN;
      busy_q  <= 1'b1;
`else
      state_q <= IDLE;
      busy_q  <= 1'b0;
`endif
      col_q     <= COL_ZERO;
      row_q     <= ROW_ZERO;
      cnt_q     <= CNT_ZERO;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cursor_col = col_q;
  assign o_cursor_row = row_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_text_writer.sv
module tb_text_writer;

  localparam logic [7:0] CLR = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] ch = 8'h00;
  logic       ready, wr_en, busy;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] ccol;
  logic [3:0] crow;

  always #5 clk = ~clk;

  text_writer #(.COL_BITS(5), .ROW_BITS(4), .CLEAR_CHAR(CLR)) dut (
    .i_pix_clk   (clk),
    .i_reset     (rst),
    .i_char_valid(valid),
    .i_char      (ch),
    .o_char_ready(ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_cursor_col(ccol),
    .o_cursor_row(crow),
    .o_busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a cursor plus the ordered list of writes each character
  // should produce; entries are {addr[8:0], data[7:0]}.
  int          m_row = 0;
  int          m_col = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          got_rd = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
  end

  function automatic logic [16:0] ent(input int addr, input logic [7:0] d);
    logic [8:0] a;
    a = addr[8:0];
    return {a, d};
  endfunction

  task automatic model_char(input logic [7:0] c);
    if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 16;
      for (int k = 0; k < 32; k++) exp_q.push_back(ent(m_row * 32 + k, CLR));
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col = m_col - 1;
        exp_q.push_back(ent(m_row * 32 + m_col, CLR));
      end
    end else if (c == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int k = 0; k < 512; k++) exp_q.push_back(ent(k, CLR));
    end else begin
      exp_q.push_back(ent(m_row * 32 + m_col, c));
      if (m_col == 31) begin
        m_col = 0;
        m_row = (m_row + 1) % 16;
        for (int k = 0; k < 32; k++) exp_q.push_back(ent(m_row * 32 + k, CLR));
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  // Present one character, wait (bounded) for the accept edge, update model.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ready=%b required=1 char=%02h", ready, c);
    end else begin
      valid = 1'b1;
      ch = c;
      @(posedge clk);
      #1;
      valid = 1'b0;
      model_char(c);
      $display("tx char=%02h cursor=(%0d,%0d) expected=(%0d,%0d)", c, crow, ccol, m_row, m_col);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || ready !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0 || ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%b ready=%b required busy=0 ready=1", busy, ready);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    wait_idle(700);
`else
    @(negedge clk);
    #1;
`endif
    got_rd = got_q.size();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b1;
    ch = 8'h41;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b required=0", ready); end
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 9'd0 || wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_wr got en=%b addr=%h data=%h required 0/000/00", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (crow !== 4'd0 || ccol !== 5'd0) begin failures++; $display("FAIL reset_cursor got=(%0d,%0d) required=(0,0)", crow, ccol); end
    got_rd = got_q.size();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b required=1", busy); end
    rst = 1'b0;
    for (int k = 0; k < 512; k++) exp_q.push_back(ent(k, CLR));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL clr_on_reset_busy got busy=%b ready=%b required 1/0", busy, ready); end
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    valid = 1'b0;
    model_char(8'h41);
    wait_idle(10);
    checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      failures++;
      $display("FAIL clr_on_reset_count got=%0d required=%0d", got_q.size() - got_rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL clr_on_reset_write[%0d] got=%h required=%h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size();
    exp_q.delete();
`else
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b required=1", ready); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != got_rd) begin failures++; $display("FAIL reset_no_writes got=%0d required=0", got_q.size() - got_rd); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    valid = 1'b1;
    ch = 8'h41;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b required=1", ready); end
    @(posedge clk);
    #1;
    ch = 8'h42;
    model_char(8'h41);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h000 || wr_data !== 8'h41) begin
      failures++;
      $display("FAIL b2b_write0 got en=%b addr=%h data=%h required 1/000/41", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b required=1", ready); end
    @(posedge clk);
    #1;
    valid = 1'b0;
    model_char(8'h42);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h001 || wr_data !== 8'h42) begin
      failures++;
      $display("FAIL b2b_write1 got en=%b addr=%h data=%h required 1/001/42", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (crow !== 5'(m_row) || ccol !== 5'(m_col) || ccol !== 5'd2) begin
      failures++;
      $display("FAIL b2b_cursor got=(%0d,%0d) required=(0,2)", crow, ccol);
    end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b required=1", ready); end
    @(negedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b0) begin failures++; $display("FAIL b2b_idle_wr got=%b required=0", wr_en); end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int n;
    bit ready_bad;
    do_reset();
    repeat (3) send(8'h0A);
    for (int k = 0; k < 31; k++) send(8'($urandom_range(32, 126)));
    checks++;
    if (crow !== 4'd3 || ccol !== 5'd31) begin failures++; $display("FAIL wrap_precursor got=(%0d,%0d) required=(3,31)", crow, ccol); end
    send(8'h58);
    checks++;
    if (crow !== 4'd4 || ccol !== 5'd0) begin failures++; $display("FAIL wrap_cursor got=(%0d,%0d) required=(4,0)", crow, ccol); end
    n = 0;
    ready_bad = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      if (ready !== 1'b0) ready_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL wrap_busy_cycles got=%0d required=32", n); end
    checks++;
    if (ready_bad) begin failures++; $display("FAIL wrap_ready_while_busy got=1 required=0"); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL wrap_ready_after got=%b required=1", ready); end
    @(negedge clk);
    #1;
    checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      failures++;
      $display("FAIL wrap_count got=%0d required=%0d", got_q.size() - got_rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL wrap_write[%0d] got=%h required=%h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_lf_bs();
    do_reset();
    repeat (15) send(8'h0A);
    repeat (5) send(8'($urandom_range(32, 126)));
    checks++;
    if (crow !== 4'd15 || ccol !== 5'd5) begin failures++; $display("FAIL lf_precursor got=(%0d,%0d) required=(15,5)", crow, ccol); end
    send(8'h0A);
    checks++;
    if (crow !== 4'd0 || ccol !== 5'd0) begin failures++; $display("FAIL lf_wrap_cursor got=(%0d,%0d) required=(0,0)", crow, ccol); end
    send(8'h5A);
    send(8'h0A);
    send(8'h0A);
    send(8'h08);
    checks++;
    if (crow !== 4'd2 || ccol !== 5'd0) begin failures++; $display("FAIL bs_col0_cursor got=(%0d,%0d) required=(2,0)", crow, ccol); end
    repeat (4) send(8'($urandom_range(32, 126)));
    send(8'h0D);
    repeat (4) send(8'($urandom_range(32, 126)));
    send(8'h08);
    checks++;
    if (crow !== 4'd2 || ccol !== 5'd3) begin failures++; $display("FAIL bs_cursor got=(%0d,%0d) required=(2,3)", crow, ccol); end
    wait_idle(100);
    checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      failures++;
      $display("FAIL lf_bs_count got=%0d required=%0d", got_q.size() - got_rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL lf_bs_write[%0d] got=%h required=%h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    int n_at;
    do_reset();
    send(8'h0C);
    exp_q.delete();
    for (int k = 0; k < 100; k++) exp_q.push_back(ent(k, CLR));
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_at = got_q.size();
    m_row = 0;
    m_col = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL midclr_ready_in_reset got=%b required=0", ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (crow !== 4'd0 || ccol !== 5'd0) begin failures++; $display("FAIL midclr_cursor got=(%0d,%0d) required=(0,0)", crow, ccol); end
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    for (int k = 0; k < 512; k++) exp_q.push_back(ent(k, CLR));
    wait_idle(700);
`else
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midclr_ready_after got ready=%b busy=%b required 1/0", ready, busy); end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != n_at) begin failures++; $display("FAIL midclr_writes_after_reset got=%0d required=0", got_q.size() - n_at); end
`endif
    checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      failures++;
      $display("FAIL midclr_count got=%0d required=%0d", got_q.size() - got_rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL midclr_write[%0d] got=%h required=%h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_random();
    int r;
    logic [7:0] c;
    do_reset();
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      if (r < 8) c = 8'h0A;
      else if (r < 12) c = 8'h0D;
      else if (r < 22) c = 8'h08;
      else if (r < 23) c = 8'h0C;
      else c = 8'($urandom_range(0, 255));
      send(c);
      checks++;
      if (crow !== 4'(m_row) || ccol !== 5'(m_col)) begin
        failures++;
        $display("FAIL rand_cursor[%0d] got=(%0d,%0d) required=(%0d,%0d)", t, crow, ccol, m_row, m_col);
      end
    end
    wait_idle(700);
    checks++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d required=%0d", got_q.size() - got_rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL rand_write[%0d] got=%h required=%h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_lf_bs();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
